// File: rtl/vinst_queue.sv
// vinst_queue: show-ahead instruction FIFO feeding the array-control stage, with flush, stall, underflow flag and issue counter.
package sa_pkg;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  dst;
    logic [7:0]  src;
    logic [15:0] imm;
  } sa_inst_t;
endpackage

module vinst_queue
  import sa_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_vld,
  input  sa_inst_t                 wr_inst,
  output logic                     wr_rdy,
  output sa_inst_t                 inst,
  output logic                     iavail,
  input  logic                     ird,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     err_clr,
  output logic                     err_udf,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNTW-1:0]          n_issued
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_c = (AW+1)'(DEPTH);
  sa_inst_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic empty, push, pop;
  assign empty  = count == '0;
  assign wr_rdy = !reset && count != full_c;
  assign push   = wr_vld && wr_rdy && !flush;
  assign pop    = ird && !empty && !flush;
  assign iavail = !empty && !stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_udf  <= 1'b0;
      n_issued <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + AW'(1);
          n_issued <= n_issued + CNTW'(1);
        end
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      err_udf <= (ird && empty && !flush) || (err_udf && !err_clr);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_inst;
  // an empty queue must never expose a stale opcode downstream
  always_comb begin
    inst = mem[rd_ptr];
    if (empty) inst.opcode = '0;
  end
endmodule

// File: tb/tb_vinst_queue.sv
// tb_vinst_queue: scoreboard bench; stimulus queues expected pops, a negedge monitor checks inst on every honoured pop.
module tb_vinst_queue;
  import sa_pkg::*;
  logic clk = 0, reset = 1, wr_vld = 0, ird = 0, flush = 0, stall = 0, err_clr = 0;
  sa_inst_t wr_inst = '0, inst;
  logic wr_rdy, iavail, err_udf;
  logic [3:0] count;
  logic [15:0] n_issued;
  sa_inst_t exp_q[$];
  int dir_cmp = 0, dir_bad = 0, mon_cmp = 0, mon_bad = 0;
  int n_base;

  vinst_queue #(.DEPTH(8), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .wr_vld(wr_vld), .wr_inst(wr_inst), .wr_rdy(wr_rdy),
    .inst(inst), .iavail(iavail), .ird(ird), .flush(flush), .stall(stall),
    .err_clr(err_clr), .err_udf(err_udf), .count(count), .n_issued(n_issued)
  );

  always #5 clk = ~clk;

  function automatic sa_inst_t mk(input int op, input int tag);
    sa_inst_t t;
    t.opcode = op[3:0];
    t.dst    = tag[3:0];
    t.src    = tag[7:0] ^ 8'h5a;
    t.imm    = 16'(tag * 257 + 1);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    dir_cmp++;
    if (act !== exp) begin
      dir_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input sa_inst_t x);
    wr_vld = 1; wr_inst = x;
    exp_q.push_back(x);
    cyc();
    wr_vld = 0;
  endtask

  always @(negedge clk)
    if (!reset && ird && !flush && iavail) begin
      mon_cmp++;
      if (exp_q.size() == 0) begin
        mon_bad++;
        $display("FAIL pop_order: got %0h expected nothing queued", inst);
      end else begin
        sa_inst_t e;
        e = exp_q.pop_front();
        if (inst !== e) begin
          mon_bad++;
          $display("FAIL pop_order: got %0h expected %0h", inst, e);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_iavail", 32'(iavail), 0);
    chk("rst_opcode", 32'(inst.opcode), 0);
    chk("rst_n_issued", 32'(n_issued), 0);
    chk("rst_err", 32'(err_udf), 0);
    chk("rst_wr_rdy", 32'(wr_rdy), 1);
    // single push / pop
    push(mk(3, 1));
    chk("a_iavail", 32'(iavail), 1);
    chk("a_inst", 32'(inst), 32'(mk(3, 1)));
    ird = 1; cyc(); ird = 0;
    chk("a_count", 32'(count), 0);
    chk("a_iavail_off", 32'(iavail), 0);
    chk("a_opcode_nop", 32'(inst.opcode), 0);
    chk("a_n_issued", 32'(n_issued), 1);
    // fill, held push, wrap
    for (int i = 0; i < 8; i++) push(mk(i + 1, 16 + i));
    chk("full_count", 32'(count), 8);
    chk("full_wr_rdy", 32'(wr_rdy), 0);
    wr_vld = 1; wr_inst = mk(9, 24);
    cyc();
    chk("held_count", 32'(count), 8);
    chk("held_wr_rdy", 32'(wr_rdy), 0);
    ird = 1; cyc(); ird = 0;
    chk("pop_full_wr_rdy", 32'(wr_rdy), 1);
    chk("pop_full_count", 32'(count), 7);
    exp_q.push_back(mk(9, 24));
    cyc(); wr_vld = 0;
    chk("held_accepted", 32'(count), 8);
    ird = 1;
    for (int i = 0; i < 8; i++) cyc();
    ird = 0;
    chk("drain_count", 32'(count), 0);
    chk("drain_n_issued", 32'(n_issued), 10);
    // streaming at count 3
    for (int i = 0; i < 3; i++) push(mk(5, 40 + i));
    n_base = n_issued;
    for (int i = 0; i < 20; i++) begin
      wr_vld = 1; wr_inst = mk(i % 15 + 1, 60 + i); ird = 1;
      exp_q.push_back(wr_inst);
      cyc();
    end
    wr_vld = 0; ird = 0;
    chk("stream_count", 32'(count), 3);
    chk("stream_n_issued", 32'(n_issued) - 32'(n_base), 20);
    ird = 1; for (int i = 0; i < 3; i++) cyc(); ird = 0;
    chk("stream_drained", 32'(count), 0);
    // underflow flag
    ird = 1; cyc(); ird = 0;
    chk("udf_set", 32'(err_udf), 1);
    chk("udf_count", 32'(count), 0);
    chk("udf_n_issued", 32'(n_issued), 33);
    err_clr = 1; cyc(); err_clr = 0;
    chk("udf_clr", 32'(err_udf), 0);
    err_clr = 1; ird = 1; cyc(); err_clr = 0; ird = 0;
    chk("udf_set_wins", 32'(err_udf), 1);
    err_clr = 1; cyc(); err_clr = 0;
    // empty push + ird: push accepted, pop ignored
    wr_vld = 1; wr_inst = mk(7, 90); ird = 1;
    exp_q.push_back(wr_inst);
    cyc(); wr_vld = 0; ird = 0;
    chk("empty_pushpop_count", 32'(count), 1);
    chk("empty_pushpop_err", 32'(err_udf), 1);
    chk("empty_pushpop_inst", 32'(inst), 32'(mk(7, 90)));
    ird = 1; cyc(); ird = 0;
    err_clr = 1; cyc(); err_clr = 0;
    // stall
    for (int i = 0; i < 5; i++) push(mk(2, 100 + i));
    stall = 1; #1;
    chk("stall_iavail", 32'(iavail), 0);
    chk("stall_count", 32'(count), 5);
    stall = 0; #1;
    chk("unstall_iavail", 32'(iavail), 1);
    ird = 1; cyc(); ird = 0;
    // flush with push and pop
    n_base = n_issued;
    chk("preflush_count", 32'(count), 4);
    flush = 1; wr_vld = 1; wr_inst = mk(15, 200); ird = 1;
    cyc();
    flush = 0; wr_vld = 0; ird = 0;
    exp_q.delete();
    chk("flush_count", 32'(count), 0);
    chk("flush_n_issued", 32'(n_issued), 32'(n_base));
    chk("flush_err", 32'(err_udf), 0);
    chk("flush_iavail", 32'(iavail), 0);
    // reset mid-operation
    for (int i = 0; i < 6; i++) push(mk(4, 120 + i));
    reset = 1; #1;
    chk("rst_hi_wr_rdy", 32'(wr_rdy), 0);
    cyc();
    exp_q.delete();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_iavail", 32'(iavail), 0);
    chk("midrst_n_issued", 32'(n_issued), 0);
    reset = 0;
    push(mk(6, 130));
    chk("post_rst_inst", 32'(inst), 32'(mk(6, 130)));
    ird = 1; cyc(); ird = 0;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", dir_cmp + mon_cmp, dir_bad + mon_bad);
    $finish;
  end
endmodule
